// File: rtl/router_switch_alloc_if.sv
// Handshake bundle between the router input buffers/crossbar and the switch allocator.
// Latency: none, plain wires.
// Backpressure: out_ready flows toward the allocator; grant/out_valid flow back.
interface router_switch_alloc_if;
    logic [4:0]  req_valid;
    logic [4:0]  req_head;
    logic [4:0]  req_tail;
    logic [19:0] req_dx;
    logic [19:0] req_dy;
    logic [4:0]  out_ready;
    logic [4:0]  grant;
    logic [4:0]  out_valid;
    logic [14:0] out_sel;
    logic [4:0]  out_busy;

    // Router side: presents flits and downstream readiness, consumes grants/selects.
    modport master (
        output req_valid, req_head, req_tail, req_dx, req_dy, out_ready,
        input  grant, out_valid, out_sel, out_busy
    );

    // Allocator side.
    modport slave (
        input  req_valid, req_head, req_tail, req_dx, req_dy, out_ready,
        output grant, out_valid, out_sel, out_busy
    );
endinterface

// File: rtl/router_switch_alloc.sv
// Wormhole switch allocator: XY route for head flits, per-output round-robin, grant held per packet.
// Latency: 0 cycles, grant/out_valid/out_sel are combinational from state and requests.
// Backpressure: out_ready low stalls the output; a locked output keeps its owner until the tail transfers.
module router_switch_alloc #(
    parameter logic [3:0] XCOORD = 4'b0001,
    parameter logic [3:0] YCOORD = 4'b0001
) (
    input  logic                 clk,
    input  logic                 reset,
    router_switch_alloc_if.slave sa
);
    localparam int NP = 5;

    typedef enum logic {
        OUT_IDLE   = 1'b0,
        OUT_LOCKED = 1'b1
    } out_state_e;

    out_state_e  out_st_q [NP];
    out_state_e  out_st_d [NP];
    logic [2:0]  owner_q  [NP];
    logic [2:0]  owner_d  [NP];
    logic [2:0]  ptr_q    [NP];
    logic [2:0]  ptr_d    [NP];
    logic [2:0]  route_q  [NP];
    logic [2:0]  route_d  [NP];
    logic [NP-1:0] lock_q;
    logic [NP-1:0] lock_d;

    logic [2:0]    head_route [NP];
    logic [NP-1:0] grant_c;
    logic [NP-1:0] ovld_c;
    logic [14:0]   sel_c;
    logic [NP-1:0] busy_c;

    // Dimension-ordered routing: X is resolved first, then Y, else eject locally.
    function automatic logic [2:0] xy_route(input logic [3:0] dx, input logic [3:0] dy);
        if (dx > XCOORD)      return 3'd2;
        else if (dx < XCOORD) return 3'd3;
        else if (dy > YCOORD) return 3'd0;
        else if (dy < YCOORD) return 3'd1;
        else                  return 3'd4;
    endfunction

    function automatic logic [2:0] wrap_inc(input logic [2:0] v);
        return (v == 3'd4) ? 3'd0 : v + 3'd1;
    endfunction

    // Route every input's head flit against this router's coordinates.
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            head_route[i] = xy_route(sa.req_dx[4*i +: 4], sa.req_dy[4*i +: 4]);
        end
    end

    // Per-output arbitration and next-state: locked outputs serve their owner, idle ones round-robin over heads.
    always_comb begin
        logic [2:0] own;
        logic [2:0] idx;
        logic [2:0] win;
        logic       found;
        own      = '0;
        idx      = '0;
        win      = '0;
        found    = 1'b0;
        grant_c  = '0;
        ovld_c   = '0;
        sel_c    = '0;
        out_st_d = out_st_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        route_d  = route_q;
        lock_d   = lock_q;
        for (int o = 0; o < NP; o++) begin
            if (out_st_q[o] == OUT_LOCKED) begin
                own = owner_q[o];
                // Head bit is ignored here: a locked input's flits are all forwarded as body.
                if (sa.req_valid[own] && sa.out_ready[o] && lock_q[own] && route_q[own] == 3'(o)) begin
                    grant_c[own]     = 1'b1;
                    ovld_c[o]        = 1'b1;
                    sel_c[3*o +: 3]  = own;
                    if (sa.req_tail[own]) begin
                        out_st_d[o] = OUT_IDLE;
                        lock_d[own] = 1'b0;
                    end
                end
            end else begin
                found = 1'b0;
                win   = '0;
                idx   = ptr_q[o];
                for (int k = 0; k < NP; k++) begin
                    if (!found && sa.req_valid[idx] && sa.req_head[idx] && !lock_q[idx]
                        && head_route[idx] == 3'(o)) begin
                        found = 1'b1;
                        win   = idx;
                    end
                    idx = wrap_inc(idx);
                end
                if (found && sa.out_ready[o]) begin
                    grant_c[win]    = 1'b1;
                    ovld_c[o]       = 1'b1;
                    sel_c[3*o +: 3] = win;
                    ptr_d[o]        = wrap_inc(win);
                    // Single-flit packets pass straight through without taking the lock.
                    if (!sa.req_tail[win]) begin
                        out_st_d[o]  = OUT_LOCKED;
                        owner_d[o]   = win;
                        lock_d[win]  = 1'b1;
                        route_d[win] = 3'(o);
                    end
                end
            end
        end
    end

    // Busy mirrors the registered lock state of each output.
    always_comb begin
        busy_c = '0;
        for (int o = 0; o < NP; o++) begin
            busy_c[o] = (out_st_q[o] == OUT_LOCKED);
        end
    end

    // Reset forces every output quiet even before the state registers have cleared.
    assign sa.grant     = reset ? '0 : grant_c;
    assign sa.out_valid = reset ? '0 : ovld_c;
    assign sa.out_sel   = reset ? '0 : sel_c;
    assign sa.out_busy  = reset ? '0 : busy_c;

    // State registers: output locks, owners, round-robin pointers, input locks and stored routes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NP; i++) begin
                out_st_q[i] <= OUT_IDLE;
                owner_q[i]  <= '0;
                ptr_q[i]    <= '0;
                route_q[i]  <= '0;
            end
            lock_q <= '0;
        end else begin
            out_st_q <= out_st_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            route_q  <= route_d;
            lock_q   <= lock_d;
        end
    end
endmodule

// File: tb/tb_router_switch_alloc.sv
// Bench for the switch allocator: directed vector table, hand sequences, then randomized packets vs a model.
// Latency: outputs sampled on the falling edge of the cycle the inputs are driven.
// Backpressure: out_ready randomized per output in the random phase.
module tb_router_switch_alloc;
    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    router_switch_alloc_if sa_if();

    router_switch_alloc #(.XCOORD(4'd1), .YCOORD(4'd1)) dut (
        .clk   (clk),
        .reset (reset),
        .sa    (sa_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [4:0]  vld, hd, tl;
        logic [19:0] dx, dy;
        logic [4:0]  rdy;
        logic [4:0]  e_gnt, e_ovld;
        logic [14:0] e_sel;
        logic [4:0]  e_busy;
    } vec_t;

    localparam logic [4:0] R = 5'b11111;

    function automatic vec_t mk(input logic r, input logic [4:0] v, input logic [4:0] h, input logic [4:0] t,
                                input logic [19:0] x, input logic [19:0] y, input logic [4:0] rd,
                                input logic [4:0] g, input logic [4:0] ov, input logic [14:0] s,
                                input logic [4:0] b);
        vec_t e;
        e.rst = r; e.vld = v; e.hd = h; e.tl = t; e.dx = x; e.dy = y; e.rdy = rd;
        e.e_gnt = g; e.e_ovld = ov; e.e_sel = s; e.e_busy = b;
        return e;
    endfunction

    function automatic logic [19:0] at(input int p, input logic [3:0] v);
        return 20'(v) << (4 * p);
    endfunction

    task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [4:0] v, input logic [4:0] h, input logic [4:0] t,
                         input logic [19:0] x, input logic [19:0] y, input logic [4:0] rd);
        reset              = r;
        sa_if.req_valid    = v;
        sa_if.req_head     = h;
        sa_if.req_tail     = t;
        sa_if.req_dx       = x;
        sa_if.req_dy       = y;
        sa_if.out_ready    = rd;
    endtask

    task automatic apply(input vec_t v, input string name);
        @(posedge clk);
        #1;
        drive(v.rst, v.vld, v.hd, v.tl, v.dx, v.dy, v.rdy);
        @(negedge clk);
        chk({name, ".grant"},     15'(sa_if.grant),     15'(v.e_gnt));
        chk({name, ".out_valid"}, 15'(sa_if.out_valid), 15'(v.e_ovld));
        chk({name, ".out_sel"},   sa_if.out_sel,        v.e_sel);
        chk({name, ".out_busy"},  15'(sa_if.out_busy),  15'(v.e_busy));
    endtask

    // Reference routing straight from the XY rule with the router at (1,1).
    function automatic int mroute(input logic [3:0] dx, input logic [3:0] dy);
        if (dx > 4'd1) return 2;
        if (dx < 4'd1) return 3;
        if (dy > 4'd1) return 0;
        if (dy < 4'd1) return 1;
        return 4;
    endfunction

    vec_t tbl[$];

    initial begin
        logic [19:0] cx, cy, rx, ry, px, py, bx, by, nx, ny;
        int m_owner[5], m_lockdst[5], m_ptr[5];
        int plen[5], pidx[5];
        logic [3:0] pdx[5], pdy[5];

        drive(1'b1, '0, '0, '0, '0, '0, R);

        // Routing of single-flit heads from Local.
        tbl.push_back(mk(1, 5'b10000, 5'b10000, 5'b10000, at(4,2), at(4,1), R, 0, 0, 0, 0));
        tbl.push_back(mk(0, 5'b10000, 5'b10000, 5'b10000, at(4,2), at(4,1), R, 5'b10000, 5'b00100, 15'h0100, 0));
        tbl.push_back(mk(0, 5'b10000, 5'b10000, 5'b10000, at(4,0), at(4,1), R, 5'b10000, 5'b01000, 15'h0800, 0));
        tbl.push_back(mk(0, 5'b10000, 5'b10000, 5'b10000, at(4,1), at(4,2), R, 5'b10000, 5'b00001, 15'h0004, 0));
        tbl.push_back(mk(0, 5'b10000, 5'b10000, 5'b10000, at(4,1), at(4,0), R, 5'b10000, 5'b00010, 15'h0020, 0));
        tbl.push_back(mk(0, 5'b10000, 5'b10000, 5'b10000, at(4,1), at(4,1), R, 5'b10000, 5'b10000, 15'h4000, 0));
        // Contention for Local between N and S, 3-flit packets.
        cx = at(0,1) | at(1,1);
        cy = cx;
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, R, 0, 0, 0, 0));
        tbl.push_back(mk(0, 5'b00011, 5'b00011, 5'b00000, cx, cy, R, 5'b00001, 5'b10000, 15'h0000, 5'b00000));
        tbl.push_back(mk(0, 5'b00011, 5'b00010, 5'b00000, cx, cy, R, 5'b00001, 5'b10000, 15'h0000, 5'b10000));
        tbl.push_back(mk(0, 5'b00011, 5'b00010, 5'b00001, cx, cy, R, 5'b00001, 5'b10000, 15'h0000, 5'b10000));
        tbl.push_back(mk(0, 5'b00010, 5'b00010, 5'b00000, cx, cy, R, 5'b00010, 5'b10000, 15'h1000, 5'b00000));
        tbl.push_back(mk(0, 5'b00010, 5'b00000, 5'b00000, cx, cy, R, 5'b00010, 5'b10000, 15'h1000, 5'b10000));
        tbl.push_back(mk(0, 5'b00010, 5'b00000, 5'b00010, cx, cy, R, 5'b00010, 5'b10000, 15'h1000, 5'b10000));
        // Pointer for Local is now 2: input 2 beats input 0, then input 0 goes next.
        cx = at(0,1) | at(2,1);
        tbl.push_back(mk(0, 5'b00101, 5'b00101, 5'b00101, cx, cx, R, 5'b00100, 5'b10000, 15'h2000, 0));
        tbl.push_back(mk(0, 5'b00101, 5'b00101, 5'b00101, cx, cx, R, 5'b00001, 5'b10000, 15'h0000, 0));
        // Round-robin of single-flit packets from inputs 0,1,2 to West.
        rx = '0;
        ry = at(0,1) | at(1,1) | at(2,1);
        for (int k = 0; k < 6; k++) begin
            tbl.push_back(mk(0, 5'b00111, 5'b00111, 5'b00111, rx, ry, R,
                             5'(1 << (k % 3)), 5'b01000, 15'((k % 3) << 9), 0));
        end
        // Parallel N->E and W->S packets.
        px = at(0,2) | at(3,1);
        py = at(0,1) | at(3,0);
        tbl.push_back(mk(0, 5'b01001, 5'b01001, 5'b00000, px, py, R, 5'b01001, 5'b00110, 15'h0018, 5'b00000));
        tbl.push_back(mk(0, 5'b01001, 5'b00000, 5'b00000, px, py, R, 5'b01001, 5'b00110, 15'h0018, 5'b00110));
        tbl.push_back(mk(0, 5'b01001, 5'b00000, 5'b01001, px, py, R, 5'b01001, 5'b00110, 15'h0018, 5'b00110));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, px, py, R, 5'b00000, 5'b00000, 15'h0000, 5'b00000));

        foreach (tbl[n]) apply(tbl[n], $sformatf("vec%0d", n));

        // Backpressure on a locked East packet from Local while North waits with a head for East.
        bx = at(0,2) | at(4,2);
        by = at(0,1) | at(4,1);
        apply(mk(0, 5'b10001, 5'b10001, 5'b00000, bx, by, R, 5'b10000, 5'b00100, 15'h0100, 0), "bp_head");
        for (int k = 0; k < 4; k++) begin
            apply(mk(0, 5'b10001, 5'b00001, 5'b00000, bx, by, 5'b11011, 0, 0, 0, 5'b00100),
                  $sformatf("bp_stall%0d", k));
        end
        apply(mk(0, 5'b10001, 5'b00001, 5'b00000, bx, by, R, 5'b10000, 5'b00100, 15'h0100, 5'b00100), "bp_resume");
        apply(mk(0, 5'b10001, 5'b00001, 5'b10000, bx, by, R, 5'b10000, 5'b00100, 15'h0100, 5'b00100), "bp_tail");
        apply(mk(0, 5'b00001, 5'b00001, 5'b00001, bx, by, R, 5'b00001, 5'b00100, 15'h0000, 0), "bp_next");

        // Reset in the middle of a South->North packet.
        nx = at(1,1);
        ny = at(1,2);
        apply(mk(0, 5'b00010, 5'b00010, 0, nx, ny, R, 5'b00010, 5'b00001, 15'h0001, 0), "rst_head");
        apply(mk(0, 5'b00010, 5'b00000, 0, nx, ny, R, 5'b00010, 5'b00001, 15'h0001, 5'b00001), "rst_body");
        apply(mk(1, 5'b00010, 5'b00000, 0, nx, ny, R, 0, 0, 0, 0), "rst_assert");
        apply(mk(0, 5'b00010, 5'b00000, 0, nx, ny, R, 0, 0, 0, 0), "rst_orphan");
        apply(mk(0, 5'b00010, 5'b00010, 5'b00010, nx, ny, R, 5'b00010, 5'b00001, 15'h0001, 0), "rst_newhead");

        // Randomized packets against the behavioural model; start from a clean reset.
        apply(mk(1, 0, 0, 0, 0, 0, R, 0, 0, 0, 0), "rand_reset");
        for (int i = 0; i < 5; i++) begin
            m_owner[i] = -1; m_lockdst[i] = -1; m_ptr[i] = 0; plen[i] = 0; pidx[i] = 0;
            pdx[i] = '0; pdy[i] = '0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        r;
            logic [4:0]  v, h, t, rd, eg, eo, eb;
            logic [19:0] x, y;
            logic [14:0] es;
            int          gw[5];
            logic        was_locked[5];
            @(posedge clk);
            #1;
            r = ($urandom_range(99) == 0);
            v = '0; h = '0; t = '0; x = '0; y = '0; rd = '0;
            for (int i = 0; i < 5; i++) begin
                rd[i] = ($urandom_range(3) != 0);
                if (plen[i] == 0 && $urandom_range(3) == 0) begin
                    plen[i] = 1 + $urandom_range(2);
                    pidx[i] = 0;
                    pdx[i]  = 4'($urandom_range(3));
                    pdy[i]  = 4'($urandom_range(3));
                end
                if (plen[i] > 0) begin
                    v[i] = ($urandom_range(4) != 0);
                    h[i] = (pidx[i] == 0);
                    t[i] = (pidx[i] == plen[i] - 1);
                    x[4*i +: 4] = pdx[i];
                    y[4*i +: 4] = pdy[i];
                end else if ($urandom_range(19) == 0) begin
                    v[i] = 1'b1;
                    t[i] = 1'($urandom_range(1));
                    x[4*i +: 4] = 4'($urandom_range(3));
                    y[4*i +: 4] = 4'($urandom_range(3));
                end
            end
            drive(r, v, h, t, x, y, rd);

            eg = '0; eo = '0; es = '0; eb = '0;
            for (int o = 0; o < 5; o++) begin
                gw[o] = -1;
                was_locked[o] = (m_owner[o] >= 0);
                if (!r) begin
                    if (m_owner[o] >= 0) begin
                        eb[o] = 1'b1;
                        if (v[m_owner[o]] && rd[o]) gw[o] = m_owner[o];
                    end else begin
                        int best, bestd;
                        best = -1; bestd = 99;
                        for (int i = 0; i < 5; i++) begin
                            if (v[i] && h[i] && m_lockdst[i] < 0
                                && mroute(x[4*i +: 4], y[4*i +: 4]) == o
                                && (i - m_ptr[o] + 5) % 5 < bestd) begin
                                best  = i;
                                bestd = (i - m_ptr[o] + 5) % 5;
                            end
                        end
                        if (best >= 0 && rd[o]) gw[o] = best;
                    end
                    if (gw[o] >= 0) begin
                        eg[gw[o]] = 1'b1;
                        eo[o] = 1'b1;
                        es[3*o +: 3] = 3'(gw[o]);
                    end
                end
            end

            @(negedge clk);
            chk($sformatf("rand%0d.grant", cyc),     15'(sa_if.grant),     15'(eg));
            chk($sformatf("rand%0d.out_valid", cyc), 15'(sa_if.out_valid), 15'(eo));
            chk($sformatf("rand%0d.out_sel", cyc),   sa_if.out_sel,        es);
            chk($sformatf("rand%0d.out_busy", cyc),  15'(sa_if.out_busy),  15'(eb));

            if (r) begin
                for (int i = 0; i < 5; i++) begin
                    m_owner[i] = -1; m_lockdst[i] = -1; m_ptr[i] = 0; plen[i] = 0;
                end
            end else begin
                for (int o = 0; o < 5; o++) begin
                    if (gw[o] >= 0) begin
                        if (was_locked[o]) begin
                            if (t[gw[o]]) begin
                                m_owner[o] = -1;
                                m_lockdst[gw[o]] = -1;
                            end
                        end else begin
                            m_ptr[o] = (gw[o] + 1) % 5;
                            if (!t[gw[o]]) begin
                                m_owner[o] = gw[o];
                                m_lockdst[gw[o]] = o;
                            end
                        end
                    end
                end
                for (int i = 0; i < 5; i++) begin
                    if (eg[i]) begin
                        if (t[i]) plen[i] = 0;
                        else pidx[i]++;
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/router_switch_alloc.md
# router_switch_alloc

Switch allocator for the 5-port mesh router (N, S, E, W, Local). It takes head/body/tail flit requests from the five input buffers and computes XY routes for head flits against the router's own coordinates. It grants each output port to one input at a time with per-output round-robin, holding the grant for the whole packet (wormhole). Its outputs drive the crossbar selects and the input-buffer pop strobes inside the router.

## Interface
Port index everywhere: 0=North, 1=South, 2=East, 3=West, 4=Local.
- XCOORD, 4'b0001, router X position in the mesh
- YCOORD, 4'b0001, router Y position in the mesh
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- req_valid  in  5  input i presents a flit this cycle
- req_head  in  5  flit at input i is a head flit
- req_tail  in  5  flit at input i is a tail flit (head+tail = single-flit packet)
- req_dx  in  20  dest X of head flit, input i at [4i+3:4i]
- req_dy  in  20  dest Y of head flit, input i at [4i+3:4i]
- out_ready  in  5  downstream of output o can accept a flit
- grant  out  5  input i's flit transfers this cycle (pop strobe)
- out_valid  out  5  output o carries a flit this cycle
- out_sel  out  15  crossbar select for output o at [3o+2:3o], value 0–4; 0 when out_valid[o]=0
- out_busy  out  5  output o is locked to an in-progress packet

## Operation
- Route computation (head flits only): dx>XCOORD → East; dx<XCOORD → West; else dy>YCOORD → North; dy<YCOORD → South; else Local. Unsigned 4-bit compares.
- Per-input state: locked bit + 3-bit stored route. Per-output state: IDLE/LOCKED, 3-bit owner, 3-bit round-robin pointer ptr[o].
- Output IDLE: candidates are inputs with req_valid & req_head & !locked & route==o. The winner is the first candidate at or after ptr[o], searching upward modulo 5. It is granted only if out_ready[o]=1.
  - Granted non-tail head: output → LOCKED, owner=winner; input locked with stored route=o; ptr[o]=(winner+1) mod 5.
  - Granted single-flit packet (head & tail): grant that cycle, no lock; ptr[o]=(winner+1) mod 5.
  - out_ready[o]=0: no grant; ptr unchanged.
- Output LOCKED: the owner input is granted whenever req_valid & out_ready[o]. The head bit is ignored while locked, so the flit is forwarded as body. A granted tail → output IDLE, input unlocked.
- Unlocked input presenting a non-head flit: protocol error; never granted; no state change.
- Each input targets exactly one output, so at most one grant per input; outputs arbitrate independently.
- Combinational: grant, out_valid, out_sel are functions of current state and current inputs. out_valid[o]=1 iff some input is granted to o.
- out_busy[o] = registered LOCKED state.

## Timing
- Reset (synchronous, while reset=1 at edge): all outputs IDLE, all inputs unlocked, ptr[*]=0. While reset=1: grant=0, out_valid=0, out_sel=0, out_busy=0, regardless of requests.
- Head latency: 0 cycles. A head with a free, ready output is granted in the cycle it is presented. Lock and out_busy are visible from the next cycle.
- Body/tail: granted in the same cycle that valid & out_ready are both high. Stalls indefinitely on out_ready=0 with the lock held.
- Tail release: the output is IDLE from the cycle after tail grant. A competing head waiting in that cycle may win then, so there is 1 cycle between tail and next head on an output. Back-to-back single-flit packets to one output can be granted every cycle.
- Reset mid-packet: locks dropped at the reset edge. After reset deasserts, remaining body flits of old packets are never granted (protocol-error rule).

## Test plan
- Routing, XCOORD=YCOORD=1: single-flit heads at Local with (dx,dy)=(2,1),(0,1),(1,2),(1,0),(1,1) → grant with out_valid on E,W,N,S,L respectively, out_sel=4, same cycle.
- Contention: N and S heads both to Local (dx=dy=1), 3-flit packets, after reset. N (ptr 0) wins; out_sel[14:12]=0 for 3 cycles; out_busy[4]=1. S is granted the cycle after N's tail, then ptr[4]=2.
- Round-robin fairness: inputs 0,1,2 continuously send single-flit packets to West → grants rotate 0,1,2,0,1,2 on consecutive cycles.
- Backpressure: locked E packet, out_ready[2]=0 for 4 cycles mid-packet → no grant, out_busy[2] stays 1, no other input gains E. Transfer resumes the cycle out_ready returns.
- Parallel: N→E and W→S packets simultaneously → both granted every cycle, independent out_sel.
- Reset mid-packet, then body flit without head → no grant, out_busy=0. A new head is then accepted normally.
